// File: rtl/game_sound_sequencer.sv
// -----------------------------------------------------------------------------
// game_sound_sequencer
//
// Turns hit/miss events from the whack-a-mole datapath into fixed-length
// square-wave tones and writes them, one stereo sample at a time, into the
// audio-codec output FIFO. A hit plays a high pitch and a miss plays a low
// pitch. Events that arrive while a tone is playing wait in a one-deep
// pending slot, and a miss takes priority over a hit.
//
// Ports:
//   clk                      system clock (only clock)
//   resetn                   synchronous active-low reset
//   hit_miss[1:0]            event code: 00 none, 01 hit, 10/11 miss
//   audio_out_allowed        codec FIFO has space
//   write_audio_out          one-cycle write strobe to the codec FIFO
//   left_channel_audio_out   sample, valid while write_audio_out=1
//   right_channel_audio_out  same sample as the left channel
//   busy                     a tone is playing
//   sound_id[1:0]            tone playing now: 00 none, 01 hit, 10 miss
// -----------------------------------------------------------------------------
module game_sound_sequencer #(
    parameter int                  SAMPLE_W     = 24,
    parameter logic [SAMPLE_W-1:0] AMPLITUDE    = 24'h0FFFFF,
    parameter int                  HIT_HALF     = 24,
    parameter int                  MISS_HALF    = 120,
    parameter int                  TONE_SAMPLES = 12000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [1:0]          hit_miss,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [SAMPLE_W-1:0] left_channel_audio_out,
    output logic [SAMPLE_W-1:0] right_channel_audio_out,
    output logic                busy,
    output logic [1:0]          sound_id
);

    localparam int HALF_MAX = (HIT_HALF > MISS_HALF) ? HIT_HALF : MISS_HALF;
    localparam int HC_W     = $clog2(HALF_MAX + 1);
    localparam int SC_W     = $clog2(TONE_SAMPLES + 1);

    localparam logic [SAMPLE_W-1:0] POS_AMP     = AMPLITUDE;
    localparam logic [SAMPLE_W-1:0] NEG_AMP     = SAMPLE_W'(0) - AMPLITUDE;
    localparam logic [HC_W-1:0]     HIT_LAST    = HC_W'(HIT_HALF - 1);
    localparam logic [HC_W-1:0]     MISS_LAST   = HC_W'(MISS_HALF - 1);
    localparam logic [SC_W-1:0]     LAST_SAMPLE = SC_W'(TONE_SAMPLES - 1);

    localparam logic [1:0] ID_NONE = 2'b00;
    localparam logic [1:0] ID_HIT  = 2'b01;
    localparam logic [1:0] ID_MISS = 2'b10;

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t              state,      state_n;
    logic [1:0]          prev_hm;
    logic                pend_valid, pend_valid_n;
    logic                pend_miss,  pend_miss_n;
    logic [1:0]          sound_id_n;
    logic                busy_n;
    logic                write_n;
    logic [SAMPLE_W-1:0] sample_q,   sample_n;
    logic [HC_W-1:0]     half_cnt,   half_n;
    logic [SC_W-1:0]     sample_cnt, cnt_n;
    logic                phase,      phase_n;

    logic                req;
    logic                req_miss;
    logic [HC_W-1:0]     half_last;

    // A new event is any non-zero code that differs from last cycle's code,
    // so a held code fires once and a direct 01->10 change fires again.
    assign req       = (hit_miss != 2'b00) && (hit_miss != prev_hm);
    assign req_miss  = hit_miss[1];
    assign half_last = (sound_id == ID_MISS) ? MISS_LAST : HIT_LAST;

    always_comb begin
        // NOTE: every signal written here gets its default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_n      = state;
        pend_valid_n = pend_valid;
        pend_miss_n  = pend_miss;
        sound_id_n   = sound_id;
        busy_n       = busy;
        write_n      = 1'b0;
        sample_n     = sample_q;
        half_n       = half_cnt;
        cnt_n        = sample_cnt;
        phase_n      = phase;

        case (state)
            IDLE: begin
                if (req) begin
                    state_n    = PLAY;
                    busy_n     = 1'b1;
                    sound_id_n = req_miss ? ID_MISS : ID_HIT;
                    half_n     = '0;
                    cnt_n      = '0;
                    phase_n    = 1'b0;
                end
            end

            PLAY: begin
                // Pending slot: empty takes anything, a held hit is upgraded
                // by a miss, a held miss ignores everything.
                if (req) begin
                    if (!pend_valid) begin
                        pend_valid_n = 1'b1;
                        pend_miss_n  = req_miss;
                    end else if (!pend_miss && req_miss) begin
                        pend_miss_n = 1'b1;
                    end
                end

                // Gating on the current strobe limits writes to one every
                // other cycle; counters only move on a write, so backpressure
                // stretches the tone without shortening it.
                if (audio_out_allowed && !write_audio_out) begin
                    write_n  = 1'b1;
                    sample_n = phase ? NEG_AMP : POS_AMP;
                    cnt_n    = sample_cnt + SC_W'(1);
                    if (half_cnt == half_last) begin
                        half_n  = '0;
                        phase_n = ~phase;
                    end else begin
                        half_n = half_cnt + HC_W'(1);
                    end

                    if (sample_cnt == LAST_SAMPLE) begin
                        half_n  = '0;
                        cnt_n   = '0;
                        phase_n = 1'b0;
                        // The slot update above already folded in a request
                        // from this very cycle, so it starts immediately.
                        if (pend_valid_n) begin
                            sound_id_n   = pend_miss_n ? ID_MISS : ID_HIT;
                            pend_valid_n = 1'b0;
                            pend_miss_n  = 1'b0;
                        end else begin
                            state_n    = IDLE;
                            busy_n     = 1'b0;
                            sound_id_n = ID_NONE;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every
        // register samples its next value from the same pre-edge snapshot.
        // prev_hm keeps tracking the input through reset, so a code that is
        // held across reset release is not mistaken for a fresh event.
        prev_hm <= hit_miss;
        if (!resetn) begin
            state           <= IDLE;
            pend_valid      <= 1'b0;
            pend_miss       <= 1'b0;
            sound_id        <= ID_NONE;
            busy            <= 1'b0;
            write_audio_out <= 1'b0;
            sample_q        <= '0;
            half_cnt        <= '0;
            sample_cnt      <= '0;
            phase           <= 1'b0;
        end else begin
            state           <= state_n;
            pend_valid      <= pend_valid_n;
            pend_miss       <= pend_miss_n;
            sound_id        <= sound_id_n;
            busy            <= busy_n;
            write_audio_out <= write_n;
            sample_q        <= sample_n;
            half_cnt        <= half_n;
            sample_cnt      <= cnt_n;
            phase           <= phase_n;
        end
    end

    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;

endmodule

// File: tb/tb_game_sound_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sound_sequencer
//
// Directed bench for game_sound_sequencer built with short tones
// (HIT_HALF=2, MISS_HALF=4, TONE_SAMPLES=8, AMPLITUDE=24'h100000).
// Inputs change and outputs are sampled on the falling edge; the DUT
// acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_game_sound_sequencer;

    localparam int          TONE = 8;
    localparam logic [23:0] POS  = 24'h100000;
    localparam logic [23:0] NEG  = 24'hF00000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  hit_miss;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [23:0] left_channel_audio_out;
    logic [23:0] right_channel_audio_out;
    logic        busy;
    logic [1:0]  sound_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    game_sound_sequencer #(
        .SAMPLE_W    (24),
        .AMPLITUDE   (24'h100000),
        .HIT_HALF    (2),
        .MISS_HALF   (4),
        .TONE_SAMPLES(TONE)
    ) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .hit_miss               (hit_miss),
        .audio_out_allowed      (audio_out_allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .busy                   (busy),
        .sound_id               (sound_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Square wave: sample idx sits in half-period idx/half; odd halves are negative.
    function automatic logic [23:0] exp_sample(input int idx, input int half);
        return (((idx / half) % 2) == 1) ? NEG : POS;
    endfunction

    // Advance to the next falling edge that shows a write strobe (bounded).
    task automatic next_write(input string tag, output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (write_audio_out !== 1'b1 && gap < 64);
        check({tag, " write seen"}, {31'd0, write_audio_out}, 32'd1);
    endtask

    // Check writes number from..to-1 of a tone.
    task automatic tone_writes(input string tag, input logic [1:0] id, input int half,
                               input int from, input int to, input int first_gap);
        int gap;
        for (int i = from; i < to; i++) begin
            next_write(tag, gap);
            if (i == from) begin
                if (first_gap > 0) check({tag, " first gap"}, gap, first_gap);
            end else begin
                check({tag, " gap"}, gap, 2);
            end
            if (i < TONE - 1) check({tag, " sound_id"}, {30'd0, sound_id}, {30'd0, id});
            check({tag, " left"},  {8'd0, left_channel_audio_out},  {8'd0, exp_sample(i, half)});
            check({tag, " right"}, {8'd0, right_channel_audio_out}, {8'd0, exp_sample(i, half)});
        end
    endtask

    task automatic tone_end(input string tag, input logic exp_busy, input logic [1:0] exp_id);
        check({tag, " end busy"},     {31'd0, busy},     {31'd0, exp_busy});
        check({tag, " end sound_id"}, {30'd0, sound_id}, {30'd0, exp_id});
    endtask

    task automatic quiet(input string tag, input int n);
        int writes = 0;
        int busies = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (write_audio_out) writes++;
            if (busy) busies++;
        end
        check({tag, " no extra writes"}, writes, 0);
        check({tag, " stays idle"},      busies, 0);
    endtask

    // Pulse a code for one rising edge and confirm the tone starts.
    task automatic start_tone(input string tag, input logic [1:0] code, input logic [1:0] exp_id);
        hit_miss = code;
        tick();
        check({tag, " start busy"},     {31'd0, busy},     32'd1);
        check({tag, " start sound_id"}, {30'd0, sound_id}, {30'd0, exp_id});
        check({tag, " start no write"}, {31'd0, write_audio_out}, 32'd0);
        hit_miss = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int held_writes;
        int held_changes;

        // 1. Reset with a hit held, then a clean hit tone.
        resetn            = 1'b0;
        hit_miss          = 2'b01;
        audio_out_allowed = 1'b1;
        tick();
        tick();
        check("reset write",    {31'd0, write_audio_out}, 32'd0);
        check("reset busy",     {31'd0, busy},            32'd0);
        check("reset sound_id", {30'd0, sound_id},        32'd0);
        check("reset left",     {8'd0, left_channel_audio_out},  32'd0);
        check("reset right",    {8'd0, right_channel_audio_out}, 32'd0);
        resetn = 1'b1;
        tick();
        tick();
        tick();
        check("held code busy",  {31'd0, busy},            32'd0);
        check("held code write", {31'd0, write_audio_out}, 32'd0);
        hit_miss = 2'b00;
        tick();
        hit_miss = 2'b01;
        tick();
        check("hit latency busy",     {31'd0, busy},     32'd1);
        check("hit latency sound_id", {30'd0, sound_id}, 32'd1);
        tone_writes("hit", 2'b01, 2, 0, TONE, 1);
        tone_end("hit", 1'b0, 2'b00);
        quiet("hit after", 6);

        // 2. Miss tone.
        start_tone("miss", 2'b10, 2'b10);
        tone_writes("miss", 2'b10, 4, 0, TONE, 1);
        tone_end("miss", 1'b0, 2'b00);
        quiet("miss after", 6);

        // 3. Backpressure after the 3rd write of a hit tone.
        start_tone("bp", 2'b01, 2'b01);
        tone_writes("bp", 2'b01, 2, 0, 3, 1);
        audio_out_allowed = 1'b0;
        held_writes  = 0;
        held_changes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (write_audio_out) held_writes++;
            if (left_channel_audio_out !== NEG) held_changes++;
        end
        check("bp stalled writes",  held_writes,  0);
        check("bp held sample",     held_changes, 0);
        check("bp held busy",       {31'd0, busy}, 32'd1);
        audio_out_allowed = 1'b1;
        tone_writes("bp", 2'b01, 2, 3, TONE, 1);
        tone_end("bp", 1'b0, 2'b00);
        quiet("bp after", 6);

        // 4a. Hit pending upgraded to miss by a later miss.
        start_tone("arb1", 2'b01, 2'b01);
        tone_writes("arb1", 2'b01, 2, 0, 2, 1);
        hit_miss = 2'b01;
        tone_writes("arb1", 2'b01, 2, 2, 3, 2);
        hit_miss = 2'b10;
        tone_writes("arb1", 2'b01, 2, 3, 4, 2);
        hit_miss = 2'b00;
        tone_writes("arb1", 2'b01, 2, 4, TONE, 2);
        tone_end("arb1", 1'b1, 2'b10);
        tone_writes("arb1 next", 2'b10, 4, 0, TONE, 2);
        tone_end("arb1 next", 1'b0, 2'b00);
        quiet("arb1 after", 6);

        // 4b. Miss pending, later hit dropped.
        start_tone("arb2", 2'b01, 2'b01);
        tone_writes("arb2", 2'b01, 2, 0, 1, 1);
        hit_miss = 2'b10;
        tone_writes("arb2", 2'b01, 2, 1, 2, 2);
        hit_miss = 2'b01;
        tone_writes("arb2", 2'b01, 2, 2, 3, 2);
        hit_miss = 2'b00;
        tone_writes("arb2", 2'b01, 2, 3, TONE, 2);
        tone_end("arb2", 1'b1, 2'b10);
        tone_writes("arb2 next", 2'b10, 4, 0, TONE, 2);
        tone_end("arb2 next", 1'b0, 2'b00);
        quiet("arb2 after", 6);

        // 5. Hit raised in the cycle of the final miss write.
        start_tone("same", 2'b10, 2'b10);
        tone_writes("same", 2'b10, 4, 0, TONE - 1, 1);
        tick();
        check("same gap no write", {31'd0, write_audio_out}, 32'd0);
        hit_miss = 2'b01;
        tone_writes("same", 2'b10, 4, TONE - 1, TONE, 1);
        tone_end("same", 1'b1, 2'b01);
        tone_writes("same next", 2'b01, 2, 0, TONE, 2);
        tone_end("same next", 1'b0, 2'b00);
        hit_miss = 2'b00;
        quiet("same after", 6);

        // 6. Reset after the 4th write with a miss pending.
        start_tone("mrst", 2'b01, 2'b01);
        tone_writes("mrst", 2'b01, 2, 0, 1, 1);
        hit_miss = 2'b10;
        tone_writes("mrst", 2'b01, 2, 1, 2, 2);
        hit_miss = 2'b00;
        tone_writes("mrst", 2'b01, 2, 2, 4, 2);
        resetn = 1'b0;
        tick();
        check("mrst write",    {31'd0, write_audio_out}, 32'd0);
        check("mrst busy",     {31'd0, busy},            32'd0);
        check("mrst sound_id", {30'd0, sound_id},        32'd0);
        check("mrst left",     {8'd0, left_channel_audio_out},  32'd0);
        check("mrst right",    {8'd0, right_channel_audio_out}, 32'd0);
        resetn = 1'b1;
        quiet("mrst after", 30);
        start_tone("mrst new", 2'b01, 2'b01);
        tone_writes("mrst new", 2'b01, 2, 0, TONE, 1);
        tone_end("mrst new", 1'b0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
